mdu_hilo_unit: RTL and testbench
================================

Name: mdu_hilo_unit

Overview:
- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline. It consumes the MD control bundle produced by the D-stage signal decoder: Start, MDUOP, Time and ReadHILO.
- Owns the HI and LO registers.
- Runs multi-cycle MULT/MULTU/DIV/DIVU, and single-cycle MTHI/MTLO/SHL writes.
- Provides Busy to the hazard unit, and HI/LO read data for MFHI/MFLO.

Parameters:
- MULT_CYCLES, 5, informational only: the expected Time for MULT/MULTU. The block uses the Time port, not this parameter.
- DIV_CYCLES, 10, informational only: the expected Time for DIV/DIVU.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- Start  input  1  launches a MULT/MULTU/DIV/DIVU in this cycle.
- MDUOP  input  4  operation code:
  - 0001 MULT, 0010 MULTU, 0011 DIV, 0100 DIVU
  - 0101 MTHI, 0110 MTLO, 1000 SHL
  - 1111 MFHI/MFLO (no write); 0000 none
- Time  input  4  busy length in cycles for the launched operation (5 or 10).
- ReadHILO  input  2  read select: 10 = HI, 01 = LO, otherwise zero.
- A  input  32  forwarded rs value.
- B  input  32  forwarded rt value.
- Busy  output  1  an operation is in flight.
- HILOOut  output  32  selected HI/LO value.

Behaviour:
- Reset (synchronous, active-high) clears HI, LO, the counter, the pending result registers and the pending-op state. Busy = 0 and HILOOut = 0 in the cycle after reset.
- Reset mid-operation aborts the operation; HI and LO stay 0.
- Two states:
  - IDLE: counter == 0.
  - RUN: counter != 0.
  - Busy = (counter != 0), registered-state derived with no combinational path from Start.
- IDLE with Start = 1 and MDUOP in {0001..0100}:
  - Latch the result into pending registers PH/PL, computed from A and B this cycle.
  - counter <= Time; go to RUN.
  - If Time == 0, write HI/LO directly at this edge and stay IDLE.
- RUN: counter decrements by 1 each edge. On the edge where counter goes 1 -> 0: HI <= PH, LO <= PL; return to IDLE.
- Busy is high for exactly Time cycles after the Start cycle. The new HI/LO is visible in the first cycle Busy is low.
- Result rules:
  - MULT: {PH,PL} = signed 64-bit product.
  - MULTU: {PH,PL} = unsigned 64-bit product.
  - DIV: PL = signed quotient truncated toward zero; PH = remainder with the sign of the dividend.
    - 0x80000000 / 0xFFFFFFFF gives PL = 0x80000000, PH = 0.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (B == 0): HI and LO are left unchanged at completion. Busy still lasts Time cycles.
- Single-cycle writes, taken only when IDLE and Start = 0, at the edge of the issuing cycle:
  - MTHI: HI <= A.
  - MTLO: LO <= A.
  - SHL: {HI,LO} <= {HI,LO} << A[4:0], 64-bit logical shift; a shift of 0 leaves HI/LO unchanged.
- While Busy:
  - Start and all write opcodes are ignored; the hazard unit guarantees none are issued.
  - Reads still return the old HI/LO.
- HILOOut is combinational from the committed HI/LO and ReadHILO.
  - There is no bypass from PH/PL.
  - ReadHILO = 11 or 00 gives 0.
- MDUOP = 1111 or 0000 with Start = 0: no state change.
- Start = 1 with an MDUOP outside 0001..0100: no state change.

Test Plan:
- Reset mid-run: assert reset during cycle 3 of a MULT -> next cycle Busy = 0, HI = LO = 0, and no later write occurs.
- MULT with A = 0xFFFFFFFE (-2), B = 3, Time = 5, Start pulse:
  - Busy = 1 for exactly 5 cycles.
  - Then HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
  - ReadHILO = 10 during Busy returns the old HI.
- MULTU with A = 0xFFFFFFFF, B = 0xFFFFFFFF, Time = 5 -> HI = 0xFFFFFFFE, LO = 0x00000001.
- DIV cases:
  - A = 0xFFFFFFF9 (-7), B = 2, Time = 10 -> Busy = 1 for 10 cycles, then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - DIVU with B = 0 -> HI/LO unchanged after 10 Busy cycles.
- Writes and shift:
  - MTHI A = 0x12345678, then MTLO A = 0x9ABCDEF0 -> reads return those values the next cycle.
  - Then SHL A = 4 -> HI = 0x23456789, LO = 0xABCDEF00.
- Start with MDUOP = 0011 issued while Busy from an earlier MULT -> ignored: Busy ends on the original schedule and HI/LO hold the MULT result.

Source files
------------

// File: rtl/mdu_hilo_unit_if.sv
// MD control bundle between the E-stage pipeline and the HI/LO multiply/divide unit.
// The pipeline side is the master. The MDU side is the slave.
interface mdu_hilo_unit_if;
  logic        Start;
  logic [3:0]  MDUOP;
  logic [3:0]  Time;
  logic [1:0]  ReadHILO;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HILOOut;

  modport master (
    output Start, MDUOP, Time, ReadHILO, A, B,
    input  Busy, HILOOut
  );

  modport slave (
    input  Start, MDUOP, Time, ReadHILO, A, B,
    output Busy, HILOOut
  );
endinterface

// File: rtl/mdu_hilo_unit.sv
// E-stage multiply/divide unit that owns HI/LO.
// The result is computed at launch, held in PH/PL, and committed after Time busy cycles.
module mdu_hilo_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic           clk,
  input  logic           reset,
  mdu_hilo_unit_if.slave md_if
);

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MTHI  = 4'b0101;
  localparam logic [3:0] OP_MTLO  = 4'b0110;
  localparam logic [3:0] OP_SHL   = 4'b1000;

  // The cycle counts are documentation only. A value the 4-bit Time port cannot carry is rejected here.
  if (MULT_CYCLES < 0 || MULT_CYCLES > 15 || DIV_CYCLES < 0 || DIV_CYCLES > 15) begin : g_param_check
    $error("mdu_hilo_unit: cycle parameters must fit the 4-bit Time port");
  end

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] ph_q, ph_d, pl_q, pl_d;
  logic        wr_q, wr_d;

  logic        is_md_op;
  logic        res_ok;
  logic [31:0] res_hi, res_lo;
  logic [63:0] mul_s, mul_u, shl_res;
  logic        neg_a, neg_b;
  logic [31:0] abs_a, abs_b, num, den, quo, rem;

  // A single shared divider. DIV runs on magnitudes, and the signs are fixed up afterwards.
  // This also makes 0x80000000 / -1 wrap to 0x80000000 without an overflow case.
  always_comb begin
    neg_a   = md_if.A[31];
    neg_b   = md_if.B[31];
    abs_a   = neg_a ? -md_if.A : md_if.A;
    abs_b   = neg_b ? -md_if.B : md_if.B;
    num     = (md_if.MDUOP == OP_DIV) ? abs_a : md_if.A;
    den     = (md_if.MDUOP == OP_DIV) ? abs_b : md_if.B;
    quo     = (den == '0) ? '0 : num / den;
    rem     = (den == '0) ? '0 : num % den;
    mul_s   = {{32{md_if.A[31]}}, md_if.A} * {{32{md_if.B[31]}}, md_if.B};
    mul_u   = {32'b0, md_if.A} * {32'b0, md_if.B};
    shl_res = {hi_q, lo_q} << md_if.A[4:0];
  end

  always_comb begin
    is_md_op = 1'b1;
    res_ok   = 1'b1;
    res_hi   = '0;
    res_lo   = '0;
    case (md_if.MDUOP)
      OP_MULT:  {res_hi, res_lo} = mul_s;
      OP_MULTU: {res_hi, res_lo} = mul_u;
      OP_DIV: begin
        res_lo = (neg_a ^ neg_b) ? -quo : quo;
        res_hi = neg_a ? -rem : rem;
        res_ok = (md_if.B != '0);
      end
      OP_DIVU: begin
        res_lo = quo;
        res_hi = rem;
        res_ok = (md_if.B != '0);
      end
      default: begin
        is_md_op = 1'b0;
        res_ok   = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    ph_d    = ph_q;
    pl_d    = pl_q;
    wr_d    = wr_q;
    case (state_q)
      ST_IDLE: begin
        if (md_if.Start) begin
          if (is_md_op) begin
            if (md_if.Time == '0) begin
              if (res_ok) begin
                hi_d = res_hi;
                lo_d = res_lo;
              end
            end else begin
              ph_d    = res_hi;
              pl_d    = res_lo;
              wr_d    = res_ok;
              cnt_d   = md_if.Time;
              state_d = ST_RUN;
            end
          end
        end else begin
          case (md_if.MDUOP)
            OP_MTHI: hi_d = md_if.A;
            OP_MTLO: lo_d = md_if.A;
            OP_SHL:  {hi_d, lo_d} = shl_res;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_IDLE;
          wr_d    = 1'b0;
          if (wr_q) begin
            hi_d = ph_q;
            lo_d = pl_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      ph_q    <= '0;
      pl_q    <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ph_q    <= ph_d;
      pl_q    <= pl_d;
      wr_q    <= wr_d;
    end
  end

  assign md_if.Busy = (state_q == ST_RUN);

  always_comb begin
    case (md_if.ReadHILO)
      2'b10:   md_if.HILOOut = hi_q;
      2'b01:   md_if.HILOOut = lo_q;
      default: md_if.HILOOut = '0;
    endcase
  end

endmodule

// File: tb/tb_mdu_hilo_unit.sv
// Bench for mdu_hilo_unit: directed scenarios plus random traffic.
// Every cycle is checked against a cycle-stamped HI/LO reference.
module tb_mdu_hilo_unit;
  logic clk = 1'b0;
  logic reset;
  mdu_hilo_unit_if md_if ();

  mdu_hilo_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md_if (md_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: committed HI/LO, a pending result, and the cycle index at which the unit is free again.
  logic [31:0] m_hi, m_lo, m_ph, m_pl;
  bit          m_pend;
  longint      cyc, busy_until;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] rd);
    if (rd == 2'b10) return m_hi;
    if (rd == 2'b01) return m_lo;
    return 32'h0;
  endfunction

  function automatic void model_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                       output bit ok, output logic [31:0] h, output logic [31:0] l);
    longint          sa, sb, sp, q, r;
    longint unsigned up;
    logic [63:0]     w;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ok = 1'b1;
    h  = '0;
    l  = '0;
    case (op)
      4'd1: begin sp = sa * sb; w = sp; h = w[63:32]; l = w[31:0]; end
      4'd2: begin up = longint'(a) * longint'(b); w = up; h = w[63:32]; l = w[31:0]; end
      4'd3: if (b == 0) ok = 1'b0; else begin
        q = sa / sb; r = sa % sb; w = q; l = w[31:0]; w = r; h = w[31:0];
      end
      4'd4: if (b == 0) ok = 1'b0; else begin l = a / b; h = a % b; end
      default: ok = 1'b0;
    endcase
  endfunction

  function automatic void model_edge(input bit st, input logic [3:0] op, input logic [3:0] tm,
                                     input logic [31:0] a, input logic [31:0] b, input bit rst);
    bit          ok;
    logic [31:0] h, l;
    if (rst) begin
      m_hi = '0; m_lo = '0; m_pend = 1'b0;
      cyc++;
      busy_until = cyc;
      return;
    end
    if (cyc >= busy_until) begin
      if (st && op >= 4'd1 && op <= 4'd4) begin
        model_result(op, a, b, ok, h, l);
        $display("issue op=%0d a=%h b=%h time=%0d -> ok=%0d hi=%h lo=%h", op, a, b, tm, ok, h, l);
        m_ph = h; m_pl = l; m_pend = ok;
        busy_until = cyc + longint'(tm) + 1;
      end else if (!st) begin
        case (op)
          4'd5: begin m_hi = a; $display("mthi a=%h", a); end
          4'd6: begin m_lo = a; $display("mtlo a=%h", a); end
          4'd8: begin {m_hi, m_lo} = {m_hi, m_lo} << a[4:0]; $display("shl a=%0d", a[4:0]); end
          default: ;
        endcase
      end
    end
    cyc++;
    if (m_pend && cyc == busy_until) begin
      m_hi = m_ph; m_lo = m_pl; m_pend = 1'b0;
    end
  endfunction

  // One clock cycle. Inputs are applied just after an edge and outputs are checked before the next edge.
  task automatic tick(input bit st, input logic [3:0] op, input logic [3:0] tm, input logic [1:0] rd,
                      input logic [31:0] a, input logic [31:0] b, input bit rst);
    md_if.Start = st; md_if.MDUOP = op; md_if.Time = tm; md_if.ReadHILO = rd;
    md_if.A = a; md_if.B = b; reset = rst;
    #1;
    check("busy", 32'(md_if.Busy), 32'(cyc < busy_until));
    check("hilo", md_if.HILOOut, model_read(rd));
    @(posedge clk);
    model_edge(st, op, tm, a, b, rst);
    #1;
  endtask

  task automatic nop(input logic [1:0] rd);
    tick(1'b0, 4'd0, 4'd0, rd, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic read_const(input string tag, input logic [1:0] rd, input logic [31:0] exp);
    md_if.ReadHILO = rd;
    #1;
    check(tag, md_if.HILOOut, exp);
  endtask

  task automatic count_busy(input string tag, input int exp_cycles);
    int n = 0;
    while (md_if.Busy === 1'b1 && n < 30) begin
      nop(2'b10);
      n++;
    end
    check(tag, 32'(n), 32'(exp_cycles));
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] corners [4] = '{32'h0, 32'h1, 32'h8000_0000, 32'hFFFF_FFFF};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
    return $urandom();
  endfunction

  initial begin
    logic [3:0] ops   [11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd15, 4'd7, 4'd9};
    logic [3:0] times [6]  = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd10, 4'd15};
    md_if.Start = 0; md_if.MDUOP = 0; md_if.Time = 0; md_if.ReadHILO = 0; md_if.A = 0; md_if.B = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_hi = '0; m_lo = '0; m_ph = '0; m_pl = '0; m_pend = 1'b0; cyc = 0; busy_until = 0;
    check("rst_busy", 32'(md_if.Busy), 32'h0);
    read_const("rst_hi", 2'b10, 32'h0);
    read_const("rst_lo", 2'b01, 32'h0);

    // Reset during the third busy cycle of a MULT.
    tick(1'b1, 4'd1, 4'd5, 2'b10, 32'd3, 32'd4, 1'b0);
    nop(2'b01); nop(2'b10);
    tick(1'b0, 4'd0, 4'd0, 2'b10, 32'h0, 32'h0, 1'b1);
    check("rst_mid_busy", 32'(md_if.Busy), 32'h0);
    repeat (6) nop(2'b01);
    read_const("rst_mid_hi", 2'b10, 32'h0);
    read_const("rst_mid_lo", 2'b01, 32'h0);

    // MULT -2 * 3. HI is preloaded so reads during Busy show the old value.
    tick(1'b0, 4'd5, 4'd0, 2'b10, 32'hDEAD_0001, 32'h0, 1'b0);
    tick(1'b1, 4'd1, 4'd5, 2'b10, 32'hFFFF_FFFE, 32'd3, 1'b0);
    read_const("mult_old_hi", 2'b10, 32'hDEAD_0001);
    count_busy("mult_busy_len", 5);
    read_const("mult_hi", 2'b10, 32'hFFFF_FFFF);
    read_const("mult_lo", 2'b01, 32'hFFFF_FFFA);

    tick(1'b1, 4'd2, 4'd5, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    count_busy("multu_busy_len", 5);
    read_const("multu_hi", 2'b10, 32'hFFFF_FFFE);
    read_const("multu_lo", 2'b01, 32'h0000_0001);

    tick(1'b1, 4'd3, 4'd10, 2'b01, 32'hFFFF_FFF9, 32'd2, 1'b0);
    count_busy("div_busy_len", 10);
    read_const("div_lo", 2'b01, 32'hFFFF_FFFD);
    read_const("div_hi", 2'b10, 32'hFFFF_FFFF);

    tick(1'b1, 4'd4, 4'd10, 2'b01, 32'd1234, 32'd0, 1'b0);
    count_busy("divu0_busy_len", 10);
    read_const("divu0_lo", 2'b01, 32'hFFFF_FFFD);
    read_const("divu0_hi", 2'b10, 32'hFFFF_FFFF);

    tick(1'b1, 4'd3, 4'd10, 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    count_busy("divovf_busy_len", 10);
    read_const("divovf_lo", 2'b01, 32'h8000_0000);
    read_const("divovf_hi", 2'b10, 32'h0);

    tick(1'b0, 4'd5, 4'd0, 2'b00, 32'h1234_5678, 32'h0, 1'b0);
    read_const("mthi", 2'b10, 32'h1234_5678);
    tick(1'b0, 4'd6, 4'd0, 2'b00, 32'h9ABC_DEF0, 32'h0, 1'b0);
    read_const("mtlo", 2'b01, 32'h9ABC_DEF0);
    tick(1'b0, 4'd8, 4'd0, 2'b00, 32'd4, 32'h0, 1'b0);
    read_const("shl_hi", 2'b10, 32'h2345_6789);
    read_const("shl_lo", 2'b01, 32'hABCD_EF00);
    tick(1'b0, 4'd8, 4'd0, 2'b00, 32'd32, 32'h0, 1'b0);
    read_const("shl0_hi", 2'b10, 32'h2345_6789);

    // A DIV launched while a MULT is running must be ignored.
    tick(1'b1, 4'd1, 4'd5, 2'b00, 32'd7, 32'd6, 1'b0);
    tick(1'b1, 4'd3, 4'd10, 2'b00, 32'd100, 32'd7, 1'b0);
    count_busy("ign_busy_len", 4);
    read_const("ign_lo", 2'b01, 32'd42);
    read_const("ign_hi", 2'b10, 32'd0);

    for (int i = 0; i < 400; i++) begin
      logic [3:0] op;
      bit         st;
      op = ops[$urandom_range(0, 10)];
      st = (op >= 4'd1 && op <= 4'd4) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      tick(st, op, times[$urandom_range(0, 5)], 2'($urandom_range(0, 3)),
           rand_operand(), rand_operand(), ($urandom_range(0, 99) == 0));
    end
    repeat (16) nop(2'b10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
